// File: rtl/lsu_ctrl_if.sv
// Load/store controller bundle: EX-stage request, data-memory bus and
// writeback/error response signals. The controller uses the master view and
// the pipeline/memory side uses the slave view.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 64
) ();
    // EX-stage request
    logic              req_valid;
    logic              req_ready;
    logic [6:0]        lsu_op;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic [4:0]        rd;
    // Data-memory bus
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [7:0]        dmem_wstrb;
    logic [63:0]       dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [63:0]       dmem_rdata;
    // Writeback response, error report and pipeline hold
    logic              resp_valid;
    logic              resp_rf_we;
    logic [4:0]        resp_rd;
    logic [63:0]       resp_data;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] err_addr;
    logic              stall;

    modport master (
        input  req_valid, lsu_op, addr, wdata, rd,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output req_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output resp_valid, resp_rf_we, resp_rd, resp_data,
        output err_valid, err_code, err_addr, stall
    );

    modport slave (
        output req_valid, lsu_op, addr, wdata, rd,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  req_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  resp_valid, resp_rf_we, resp_rd, resp_data,
        input  err_valid, err_code, err_addr, stall
    );
endinterface

// File: rtl/lsu_ctrl.sv
// EX/MEM load/store sequencer. Takes one access at a time from the decoder,
// runs it over a req/gnt/rvalid doubleword bus, and returns either extended
// load data / store completion or an error pulse (misaligned, bad size,
// bus timeout). Holds the pipeline via stall while an access is in flight.
module lsu_ctrl #(
    parameter int          ADDR_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        ERR
    } state_t;

    // Counter value seen in the last REQ/WAIT cycle allowed before timing out
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state, state_nx;
    logic              op_we, op_uns;
    logic [3:0]        op_size;
    logic [ADDR_W-1:0] op_addr;
    logic [63:0]       op_wdata;
    logic [4:0]        op_rd;
    logic [7:0]        tmo_cnt;
    logic [63:0]       resp_data_q;
    logic [1:0]        err_code_q, err_code_nx;

    logic              accept;
    logic              size_ok;
    logic              aligned;
    logic              done;
    logic              timed_out;
    logic [7:0]        lane_mask;
    logic [63:0]       rd_shift;
    logic [63:0]       ld_ext;

    assign accept    = (state == IDLE) && bus.req_valid && bus.lsu_op[6];
    assign size_ok   = $onehot(bus.lsu_op[4:1]);
    assign done      = ((state == REQ) && bus.dmem_gnt && bus.dmem_rvalid) ||
                       ((state == WAIT) && bus.dmem_rvalid);
    assign timed_out = (tmo_cnt == TMO_LAST);

    // Alignment of the incoming byte address against the requested size
    always_comb begin
        aligned = 1'b1;
        if (bus.lsu_op[2])      aligned = ~bus.addr[0];
        else if (bus.lsu_op[3]) aligned = (bus.addr[1:0] == 2'b00);
        else if (bus.lsu_op[4]) aligned = (bus.addr[2:0] == 3'b000);
    end

    // Next-state and error-code selection
    always_comb begin
        state_nx    = state;
        err_code_nx = err_code_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!size_ok) begin
                        state_nx    = ERR;
                        err_code_nx = 2'b10;
                    end else if (!aligned) begin
                        state_nx    = ERR;
                        err_code_nx = 2'b01;
                    end else begin
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                // completion wins over timeout in the final allowed cycle
                if (bus.dmem_gnt && bus.dmem_rvalid) begin
                    state_nx = RESP;
                end else if (timed_out) begin
                    state_nx    = ERR;
                    err_code_nx = 2'b11;
                end else if (bus.dmem_gnt) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (bus.dmem_rvalid) begin
                    state_nx = RESP;
                end else if (timed_out) begin
                    state_nx    = ERR;
                    err_code_nx = 2'b11;
                end
            end
            RESP:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Byte-lane mask and load extraction from the captured access
    always_comb begin
        rd_shift = bus.dmem_rdata >> {op_addr[2:0], 3'b000};
        case (op_size)
            4'b0001: begin
                lane_mask = 8'h01;
                ld_ext    = op_uns ? {56'd0, rd_shift[7:0]}  : {{56{rd_shift[7]}},  rd_shift[7:0]};
            end
            4'b0010: begin
                lane_mask = 8'h03;
                ld_ext    = op_uns ? {48'd0, rd_shift[15:0]} : {{48{rd_shift[15]}}, rd_shift[15:0]};
            end
            4'b0100: begin
                lane_mask = 8'h0F;
                ld_ext    = op_uns ? {32'd0, rd_shift[31:0]} : {{32{rd_shift[31]}}, rd_shift[31:0]};
            end
            default: begin
                lane_mask = 8'hFF;
                ld_ext    = rd_shift;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Capture the accepted request (faulting ones too, for err_addr)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we    <= 1'b0;
            op_uns   <= 1'b0;
            op_size  <= '0;
            op_addr  <= '0;
            op_wdata <= '0;
            op_rd    <= '0;
        end else if (accept) begin
            op_we    <= bus.lsu_op[5];
            op_uns   <= bus.lsu_op[0];
            op_size  <= bus.lsu_op[4:1];
            op_addr  <= bus.addr;
            op_wdata <= bus.wdata;
            op_rd    <= bus.rd;
        end
    end

    // Bus-timeout counter: cleared on accept, counts every REQ/WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               tmo_cnt <= '0;
        else if (accept)                          tmo_cnt <= '0;
        else if (state == REQ || state == WAIT)   tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Response data and error code registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data_q <= '0;
            err_code_q  <= '0;
        end else begin
            if (done) resp_data_q <= op_we ? '0 : ld_ext;
            err_code_q <= err_code_nx;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.stall      = (state != IDLE) | (bus.req_valid & bus.lsu_op[6]);
    assign bus.dmem_req   = (state == REQ);
    assign bus.dmem_we    = op_we;
    assign bus.dmem_addr  = {op_addr[ADDR_W-1:3], 3'b000};
    assign bus.dmem_wstrb = op_we ? (lane_mask << op_addr[2:0]) : '0;
    assign bus.dmem_wdata = op_wdata << {op_addr[2:0], 3'b000};
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rf_we = (state == RESP) & ~op_we;
    assign bus.resp_rd    = ((state == RESP) && !op_we) ? op_rd : '0;
    assign bus.resp_data  = (state == RESP) ? resp_data_q : '0;
    assign bus.err_valid  = (state == ERR);
    assign bus.err_code   = (state == ERR) ? err_code_q : '0;
    assign bus.err_addr   = (state == ERR) ? op_addr : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a driver issues accesses and plays the memory bus on a
// planned timeline, pushing the expected writeback/error pulse into a
// scoreboard; a negedge monitor checks handshake/bus outputs each cycle and
// pops the scoreboard whenever the controller pulses resp_valid or err_valid.
module tb_lsu_ctrl;
    localparam int          ADDR_W = 64;
    localparam int unsigned TMO    = 4;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        int unsigned cyc;
        bit          rf_we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] eaddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        sb[$];
    bit          mon_en = 1'b0;
    bit          exp_busy = 1'b0;
    bit          exp_req = 1'b0;
    logic [63:0] exp_baddr = '0;
    bit          exp_bwe = 1'b0;
    logic [7:0]  exp_bstrb = '0;
    logic [63:0] exp_bwdata = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [6:0] mkop(bit en, bit we, logic [3:0] sz, bit uns);
        return {en, we, sz, uns};
    endfunction

    function automatic int unsigned size_bytes(logic [3:0] sz);
        case (sz)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 0;
        endcase
    endfunction

    // Load result: pick n bytes starting at byte lane off, then extend
    function automatic logic [63:0] load_model(logic [63:0] raw, int unsigned off, int unsigned n, bit uns);
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
        if (!uns && v[8*n-1])
            for (int unsigned i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Store lanes: byte b carries store byte (b-off); strobes cover n bytes
    task automatic store_model(input logic [63:0] wd, input int unsigned off, input int unsigned n,
                               output logic [7:0] strb, output logic [63:0] lanes);
        strb  = '0;
        lanes = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (b >= off && b < off + n) strb[b] = 1'b1;
            if (b >= off) lanes[8*b +: 8] = wd[8*(b-off) +: 8];
        end
    endtask

    // Monitor: per-cycle handshake/bus checks and scoreboard pops on pulses
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("req_ready", 64'(bus.req_ready), 64'(!exp_busy));
            chk("stall", 64'(bus.stall), 64'(exp_busy | (bus.req_valid & bus.lsu_op[6])));
            chk("dmem_req", 64'(bus.dmem_req), 64'(exp_req));
            if (exp_req) begin
                chk("dmem_addr", bus.dmem_addr, exp_baddr);
                chk("dmem_we", 64'(bus.dmem_we), 64'(exp_bwe));
                chk("dmem_wstrb", 64'(bus.dmem_wstrb), 64'(exp_bstrb));
                if (exp_bwe) chk("dmem_wdata", bus.dmem_wdata, exp_bwdata);
            end
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: pulse due at cycle %0d did not occur (now %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (bus.resp_valid || bus.err_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: resp_valid=%0b err_valid=%0b, expected none (cycle %0d)",
                             bus.resp_valid, bus.err_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    chk("err_valid", 64'(bus.err_valid), 64'(e.is_err));
                    chk("resp_valid", 64'(bus.resp_valid), 64'(!e.is_err));
                    if (e.is_err) begin
                        chk("err_code", 64'(bus.err_code), 64'(e.code));
                        chk("err_addr", bus.err_addr, e.eaddr);
                    end else begin
                        chk("resp_rf_we", 64'(bus.resp_rf_we), 64'(e.rf_we));
                        chk("resp_data", bus.resp_data, e.data);
                        if (e.rf_we) chk("resp_rd", 64'(bus.resp_rd), 64'(e.rd));
                    end
                end
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.req_valid   = 1'($urandom);
        bus.lsu_op      = 7'($urandom) & 7'h3F;
        bus.addr        = {$urandom, $urandom};
        bus.wdata       = {$urandom, $urandom};
        bus.rd          = 5'($urandom);
        bus.dmem_gnt    = ($urandom % 4) == 0;
        bus.dmem_rvalid = ($urandom % 4) == 0;
        bus.dmem_rdata  = {$urandom, $urandom};
        exp_busy        = 1'b0;
        exp_req         = 1'b0;
    endtask

    // One access: g = cycles of REQ before gnt, r = cycles from gnt to rvalid
    task automatic do_op(input logic [6:0] op, input logic [63:0] a, input logic [63:0] wd,
                         input logic [4:0] rdn, input int unsigned g, input int unsigned r,
                         input logic [63:0] rdat);
        exp_t        e;
        int unsigned n, off, L, lend, c0, req_last;
        bit          bus_op;
        logic [7:0]  strb;
        logic [63:0] lanes;
        @(posedge clk); #1;
        bus.req_valid   = 1'b1;
        bus.lsu_op      = op;
        bus.addr        = a;
        bus.wdata       = wd;
        bus.rd          = rdn;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        exp_busy        = 1'b0;
        exp_req         = 1'b0;
        c0      = cyc;
        off     = 32'(a[2:0]);
        n       = size_bytes(op[4:1]);
        e.rd    = rdn;
        e.rf_we = !op[5];
        e.eaddr = a;
        e.data  = '0;
        e.code  = 2'b00;
        e.is_err = 1'b1;
        bus_op  = 1'b0;
        if (n == 0) begin
            e.code = 2'b10;
            L = 1;
        end else if (off % n != 0) begin
            e.code = 2'b01;
            L = 1;
        end else begin
            bus_op = 1'b1;
            if (g + 1 <= TMO && g + 1 + r <= TMO) begin
                e.is_err = 1'b0;
                L = g + 2 + r;
                e.data = op[5] ? 64'd0 : load_model(rdat, off, n, op[0]);
            end else begin
                e.code = 2'b11;
                L = TMO + 1;
            end
            store_model(wd, off, n, strb, lanes);
            exp_baddr  = a & ~64'd7;
            exp_bwe    = op[5];
            exp_bstrb  = op[5] ? strb : 8'h00;
            exp_bwdata = lanes;
        end
        e.cyc = c0 + L;
        sb.push_back(e);
        req_last = (g + 1 < TMO) ? g + 1 : TMO;
        lend = (bus_op && g + 1 + r > L) ? g + 1 + r : L;
        for (int unsigned k = 1; k <= lend; k++) begin
            @(posedge clk); #1;
            bus.req_valid   = 1'($urandom);
            bus.lsu_op      = (k <= L) ? 7'($urandom) : (7'($urandom) & 7'h3F);
            bus.addr        = {$urandom, $urandom};
            bus.wdata       = {$urandom, $urandom};
            bus.rd          = 5'($urandom);
            exp_busy        = (k <= L);
            exp_req         = bus_op && (k <= req_last);
            bus.dmem_gnt    = bus_op && (k == g + 1);
            bus.dmem_rvalid = bus_op && (k == g + 1 + r);
            bus.dmem_rdata  = (bus_op && k == g + 1 + r) ? rdat : {$urandom, $urandom};
        end
    endtask

    // Reset asserted while an access sits in WAIT
    task automatic reset_mid_access();
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.lsu_op    = mkop(1, 0, 4'b1000, 0);
        bus.addr      = 64'h5000;
        bus.dmem_gnt  = 1'b0;
        bus.dmem_rvalid = 1'b0;
        exp_busy = 1'b0;
        exp_req  = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.dmem_gnt  = 1'b1;
        exp_busy  = 1'b1;
        exp_req   = 1'b1;
        exp_baddr = 64'h5000;
        exp_bwe   = 1'b0;
        exp_bstrb = 8'h00;
        @(posedge clk); #1;
        bus.dmem_gnt = 1'b0;
        exp_req = 1'b0;
        #1;
        exp_busy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("rst_async_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_async_dmem_addr", bus.dmem_addr, 64'd0);
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            bus.dmem_gnt = 1'b0;
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.lsu_op = '0; bus.addr = '0; bus.wdata = '0; bus.rd = '0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("reset_dmem_we", 64'(bus.dmem_we), 64'd0);
        chk("reset_dmem_addr", bus.dmem_addr, 64'd0);
        chk("reset_dmem_wstrb", 64'(bus.dmem_wstrb), 64'd0);
        chk("reset_dmem_wdata", bus.dmem_wdata, 64'd0);
        chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("reset_resp_data", bus.resp_data, 64'd0);
        chk("reset_err_valid", 64'(bus.err_valid), 64'd0);
        chk("reset_err_code", 64'(bus.err_code), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ld, gnt@1 rvalid@2 -> resp@3
        do_op(mkop(1, 0, 4'b1000, 0), 64'h1000, 64'h0, 5'd7, 0, 1, 64'h8877665544332211);
        // lb / lbu at top byte lane
        do_op(mkop(1, 0, 4'b0001, 0), 64'h1007, 64'h0, 5'd3, 0, 1, 64'h80123456789ABCDE);
        do_op(mkop(1, 0, 4'b0001, 1), 64'h1007, 64'h0, 5'd4, 1, 0, 64'h80123456789ABCDE);
        // sh to lane 2
        do_op(mkop(1, 1, 4'b0010, 0), 64'h2002, 64'hBEEF, 5'd9, 0, 0, 64'h0);
        // misaligned lw, bad sizes
        do_op(mkop(1, 0, 4'b0100, 0), 64'h3002, 64'h0, 5'd1, 0, 0, 64'h0);
        do_op(mkop(1, 0, 4'b0011, 0), 64'h3000, 64'h0, 5'd1, 0, 0, 64'h0);
        do_op(mkop(1, 1, 4'b0000, 0), 64'h3008, 64'h0, 5'd1, 0, 0, 64'h0);
        // minimum latency, completion exactly at the timeout limit, one past it
        do_op(mkop(1, 0, 4'b0100, 0), 64'h6004, 64'h0, 5'd5, 0, 0, 64'h8000_0001_7FFF_FFFF);
        do_op(mkop(1, 0, 4'b0010, 1), 64'h6006, 64'h0, 5'd6, 0, 3, 64'hF00D_1234_5678_9ABC);
        do_op(mkop(1, 0, 4'b0010, 0), 64'h6006, 64'h0, 5'd6, 3, 1, 64'hF00D_1234_5678_9ABC);
        // gnt never arrives in time, late rvalid afterwards, then a normal op
        do_op(mkop(1, 0, 4'b1000, 0), 64'h4000, 64'h0, 5'd2, 6, 1, 64'h1111);
        do_op(mkop(1, 0, 4'b1000, 0), 64'h1000, 64'h0, 5'd7, 0, 1, 64'h8877665544332211);
        reset_mid_access();
        do_op(mkop(1, 1, 4'b1000, 0), 64'h7000, 64'hCAFE_F00D_DEAD_BEEF, 5'd0, 1, 1, 64'h0);

        for (int unsigned t = 0; t < 200; t++) begin
            logic [3:0]  sz;
            logic [63:0] a;
            int unsigned nb;
            if ($urandom % 8 == 0) begin
                sz = 4'($urandom);
                while ($onehot(sz)) sz = 4'($urandom);
            end else begin
                sz = 4'b0001 << ($urandom % 4);
            end
            a  = {$urandom, $urandom};
            nb = size_bytes(sz);
            if (nb != 0 && $urandom % 4 != 0) a = a & ~64'(nb - 1);
            do_op(mkop(1, 1'($urandom), sz, 1'($urandom)), a, {$urandom, $urandom}, 5'($urandom),
                  $urandom % 5, $urandom % 4, {$urandom, $urandom});
            repeat ($urandom % 3) idle_cycle();
        end
        repeat (8) idle_cycle();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
